// File: rtl/ad_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// ad_cfg_sequencer_if : ROM fetch and SPI register-engine bus of the sequencer
// Rev 1.0
// ============================================================================
interface ad_cfg_sequencer_if #(
  parameter int IDX_W = 4
);
  logic [IDX_W-1:0] Tbl_Addr;
  logic [21:0]      Tbl_Data;
  logic             New_Word;
  logic [12:0]      Addr;
  logic [7:0]       Data;
  logic             RW;
  logic             Over;
  logic [7:0]       q;

  modport master (
    output Tbl_Addr, New_Word, Addr, Data, RW,
    input  Tbl_Data, Over, q
  );

  modport slave (
    input  Tbl_Addr, New_Word, Addr, Data, RW,
    output Tbl_Data, Over, q
  );
endinterface
`default_nettype wire

// File: rtl/ad_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// ad_cfg_sequencer : walks an ADC register table and drives the 3-wire SPI engine
// Rev 1.0
// ============================================================================
module ad_cfg_sequencer #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = 4,
  parameter int NW_CYCLES = 2,
  parameter int TIMEOUT   = 64,
  parameter int GAP       = 4
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               Start,
  ad_cfg_sequencer_if.master bus,
  output logic               Busy,
  output logic               Done,
  output logic               Err_Timeout,
  output logic               Mismatch,
  output logic [IDX_W-1:0]   Err_Index,
  output logic [7:0]         Rd_Data
);

  localparam int CNT_W = $clog2(TIMEOUT + NW_CYCLES + GAP + 1);
  localparam logic [CNT_W-1:0] NW_LAST  = CNT_W'(NW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_OVER = 3'd4,
    S_CHECK     = 3'd5,
    S_GAP       = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nw_q, nw_d;
  logic [12:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             mis_q, mis_d;
  logic [IDX_W-1:0] eidx_q, eidx_d;
  logic [7:0]       rd_q, rd_d;
  logic             err_seen;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      nw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      mis_q   <= 1'b0;
      eidx_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nw_q    <= nw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      mis_q   <= mis_d;
      eidx_q  <= eidx_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    nw_d     = nw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rw_d     = rw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmo_d    = tmo_q;
    mis_d    = mis_q;
    eidx_d   = eidx_q;
    rd_d     = rd_q;
    err_seen = tmo_q | mis_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          tmo_d   = 1'b0;
          mis_d   = 1'b0;
          eidx_d  = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT_ROM;
      S_WAIT_ROM: begin
        {rw_d, addr_d, data_d} = bus.Tbl_Data;
        nw_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q == NW_LAST) begin
          nw_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_OVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_OVER: begin
        // First cycle skipped: Over may still be high from the previous word.
        if (cnt_q != '0 && bus.Over) begin
          if (rw_q) rd_d = bus.q;
          state_d = S_CHECK;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          if (!err_seen) eidx_d = idx_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (rw_q && (rd_q != data_q)) begin
          mis_d = 1'b1;
          if (!err_seen) eidx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          if (GAP == 0) state_d = S_FETCH;
          else          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_FETCH;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Tbl_Addr = idx_q;
  assign bus.New_Word = nw_q;
  assign bus.Addr     = addr_q;
  assign bus.Data     = data_q;
  assign bus.RW       = rw_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Err_Timeout  = tmo_q;
  assign Mismatch     = mis_q;
  assign Err_Index    = eidx_q;
  assign Rd_Data      = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ad_cfg_sequencer : randomized bench with table/engine model and scoreboard
// Rev 1.0
// ============================================================================
module tb_ad_cfg_sequencer;
  localparam int N   = 4;
  localparam int IW  = 4;
  localparam int NWC = 2;
  localparam int TMO = 64;
  localparam int GP  = 4;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          Start = 1'b0;
  logic          Busy, Done, Err_Timeout, Mismatch;
  logic [IW-1:0] Err_Index;
  logic [7:0]    Rd_Data;

  ad_cfg_sequencer_if #(.IDX_W(IW)) bus ();

  ad_cfg_sequencer #(
    .N_ENTRIES(N), .IDX_W(IW), .NW_CYCLES(NWC), .TIMEOUT(TMO), .GAP(GP)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .Start(Start), .bus(bus),
    .Busy(Busy), .Done(Done), .Err_Timeout(Err_Timeout), .Mismatch(Mismatch),
    .Err_Index(Err_Index), .Rd_Data(Rd_Data)
  );

  always #5 CLK = ~CLK;

  // table contents and per-entry engine behaviour (latency after New_Word falls, read-back byte)
  logic [21:0] rom [16];
  int          lat [16];
  logic [7:0]  qv  [16];

  always @(posedge CLK) bus.Tbl_Data <= rom[bus.Tbl_Addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // run-level reference model
  bit         exp_tmo, exp_mis;
  int         exp_eidx, exp_issued;
  logic [7:0] m_rd = 8'h00;

  task automatic predict();
    exp_tmo = 0; exp_mis = 0; exp_eidx = 0; exp_issued = 0;
    for (int k = 0; k < N; k++) begin
      exp_issued = k + 1;
      if (lat[k] >= TMO) begin
        if (!exp_mis) exp_eidx = k;
        exp_tmo = 1;
        break;
      end
      if (rom[k][21]) begin
        m_rd = qv[k];
        if (qv[k] != rom[k][7:0]) begin
          if (!exp_mis) exp_eidx = k;
          exp_mis = 1;
        end
      end
    end
  endtask

  // cycle monitor + engine model
  bit          exp_busy, pend, eng_act, nw_prev, tmo_prev, over_seen;
  int          txn, since_fall, nw_len, samp, over_samp, start_samp, done_cnt;
  logic [21:0] cur;

  initial begin
    samp = 0; over_samp = -1000; start_samp = -1000; done_cnt = 0; cur = '0;
  end

  always @(negedge CLK) begin
    if (!RST_n) begin
      exp_busy = 0; pend = 0; txn = 0; eng_act = 0; nw_prev = 0; tmo_prev = 0;
      over_seen = 0; since_fall = 0; nw_len = 0;
      bus.Over = 1'b0; bus.q = 8'h00;
    end else begin
      samp++;
      if (pend) begin exp_busy = 1; pend = 0; txn = 0; end
      if (bus.New_Word && !nw_prev) begin
        chk("nw_only_when_busy", exp_busy, 1);
        if (txn == 0) chk("first_issue_delay", samp - start_samp, 3);
        else begin
          chk("over_before_next_issue", over_seen, 1);
          chk("gap_over_to_issue", samp - over_samp, GP + 4);
        end
        if (txn < 16) begin
          chk("addr", bus.Addr, rom[txn][20:8]);
          chk("data", bus.Data, rom[txn][7:0]);
          chk("rw",   bus.RW,   rom[txn][21]);
        end
        cur = {bus.RW, bus.Addr, bus.Data};
        txn++; nw_len = 0; over_seen = 0;
      end
      if (bus.New_Word) nw_len++;
      if (!bus.New_Word && nw_prev) begin
        chk("nw_width", nw_len, NWC);
        since_fall = 0; eng_act = 1;
      end else if (eng_act) since_fall++;
      if (bus.New_Word || eng_act) chk("bus_stable", {bus.RW, bus.Addr, bus.Data}, cur);
      if (Err_Timeout && !tmo_prev) chk("timeout_delay", since_fall, TMO);
      tmo_prev = Err_Timeout;
      if (Done) begin
        chk("busy_low_at_done", Busy, 0);
        chk("done_only_in_run", exp_busy, 1);
        chk("entries_issued", txn, exp_issued);
        if (exp_tmo) chk("done_at_timeout", since_fall, TMO);
        else         chk("done_after_last_over", samp - over_samp, 2);
        exp_busy = 0; eng_act = 0; done_cnt++;
      end else chk("busy", Busy, exp_busy);
      if (eng_act && txn > 0) begin
        if (since_fall == 1) bus.Over = 1'b0;
        if (since_fall == lat[txn-1]) begin
          bus.Over = 1'b1; bus.q = qv[txn-1];
          eng_act = 0; over_samp = samp; over_seen = 1;
        end
      end
      if (Start && !exp_busy && !Done) begin pend = 1; start_samp = samp; end
      nw_prev = bus.New_Word;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_tbl_addr"}, bus.Tbl_Addr, 0);
    chk({tag, "_new_word"}, bus.New_Word, 0);
    chk({tag, "_bus"}, {bus.RW, bus.Addr, bus.Data}, 0);
    chk({tag, "_flags"}, {Busy, Done, Err_Timeout, Mismatch}, 0);
    chk({tag, "_err_index"}, Err_Index, 0);
    chk({tag, "_rd_data"}, Rd_Data, 0);
  endtask

  task automatic run(input bit poke_busy, input bit poke_done);
    int d0, n;
    predict();
    d0 = done_cnt;
    @(posedge CLK); #1 Start = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
    if (poke_busy) begin
      repeat (20) @(posedge CLK);
      #1 Start = 1'b1;
      @(posedge CLK); #1 Start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 4000) begin @(negedge CLK); #1; n++; end
    chk("run_done_seen", done_cnt != d0, 1);
    if (poke_done) begin
      Start = 1'b1;
      @(posedge CLK); #1 Start = 1'b0;
    end
    @(negedge CLK); #1;
    chk("run_err_timeout", Err_Timeout, exp_tmo);
    chk("run_mismatch", Mismatch, exp_mis);
    chk("run_err_index", Err_Index, exp_eidx);
    chk("run_rd_data", Rd_Data, m_rd);
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 16; k++) begin rom[k] = '0; lat[k] = 26; qv[k] = 8'h00; end
    repeat (3) @(posedge CLK);
    #1 check_all_zero("reset");
    RST_n = 1'b1;

    // three writes, then a matching read
    rom[0] = {1'b0, 13'h014, 8'h3C};
    rom[1] = {1'b0, 13'h016, 8'h01};
    rom[2] = {1'b0, 13'h0FF, 8'h01};
    rom[3] = {1'b1, 13'h001, 8'h5A};
    qv[3]  = 8'h5A;
    run(0, 0);
    chk("t1_model_issued", exp_issued, 4);
    chk("t1_rd_data", Rd_Data, 8'h5A);
    chk("t1_flags", {Err_Timeout, Mismatch}, 2'b00);

    // mismatching read at entry 1, later entries must still run
    rom[1] = {1'b1, 13'h001, 8'h5A}; qv[1] = 8'h5B;
    rom[3] = {1'b0, 13'h014, 8'h3C};
    run(0, 0);
    chk("t2_model_eidx", exp_eidx, 1);
    chk("t2_mismatch", Mismatch, 1);
    chk("t2_err_index", Err_Index, 1);
    chk("t2_rd_data", Rd_Data, 8'h5B);

    // timeout boundaries: TMO-1 still accepted, TMO times out; Start while busy ignored
    qv[1] = 8'h5A; lat[0] = TMO - 1; lat[2] = TMO;
    run(1, 0);
    chk("t3_err_timeout", Err_Timeout, 1);
    chk("t3_err_index", Err_Index, 2);
    chk("t3_mismatch", Mismatch, 0);

    // fresh Start clears sticky errors; Start during the Done cycle ignored
    lat[0] = 26; lat[2] = 26;
    run(0, 1);
    chk("t4_cleared", {Err_Timeout, Mismatch, Err_Index}, 0);

    // mismatch first, then timeout: index keeps the earlier error
    qv[1] = 8'h5B; lat[3] = 200;
    run(0, 0);
    chk("t5_flags", {Err_Timeout, Mismatch}, 2'b11);
    chk("t5_err_index", Err_Index, 1);

    // asynchronous reset in WAIT_OVER
    lat[3] = 26; qv[1] = 8'h5A; lat[0] = 40;
    @(posedge CLK); #1 Start = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
    n = 0;
    while (!(eng_act && since_fall == 10) && n < 200) begin @(negedge CLK); #1; n++; end
    chk("reached_wait_over", eng_act && since_fall == 10, 1);
    #2 RST_n = 1'b0;
    #1 check_all_zero("mid_reset");
    m_rd = 8'h00;
    repeat (2) @(posedge CLK);
    #1 RST_n = 1'b1;
    lat[0] = 26;
    run(0, 0);

    // randomized tables and engine behaviour
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++) begin
        rom[k] = {1'($urandom), 13'($urandom), 8'($urandom)};
        lat[k] = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 4))
                                              : int'($urandom_range(2, TMO - 1));
        qv[k]  = rom[k][7:0] ^ (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      run(1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
